execute_stage: RTL and testbench

- EX stage of the 5-stage pipeline; sits directly upstream of the MEM stage and drives its sel_rd/mem_re/mem_we/mem_size/alu_result/store-data inputs through an EX/MEM pipeline register.
- Single-cycle integer ALU plus an iterative multiply/divide unit for RV32M ops.
- Raises stall_o to the decode stage while a multi-cycle op is in flight.
- Honours downstream stall_i and pipeline flush_i.

---
 rtl/execute_stage.sv | 178 +++++++++++++++++
 tb/tb_execute_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: EX pipeline stage with a 1-cycle integer ALU, an optional iterative RV32M unit and the EX/MEM register
// Build option: define RV32M_EN to build the multiply/divide FSM; otherwise M ops complete in one cycle with result 0.
// Ports: clk/rst_n (async, active-low); valid_i, alu_op_i, operand_a_i/b_i, store_data_i, sel_rd_i, mem_re_i,
//   mem_we_i, mem_size_i from decode; stall_i/flush_i from pipeline control; stall_o to decode; registered
//   sel_rd_o, mem_re_o, mem_we_o, mem_size_o, alu_result_o, store_data_o to MEM; busy_o while the M unit is active.
module execute_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int SIZE_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [4:0]            alu_op_i,
  input  logic [31:0]           operand_a_i,
  input  logic [31:0]           operand_b_i,
  input  logic [31:0]           store_data_i,
  input  logic [REG_ADDR_W-1:0] sel_rd_i,
  input  logic                  mem_re_i,
  input  logic                  mem_we_i,
  input  logic [SIZE_W-1:0]     mem_size_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [REG_ADDR_W-1:0] sel_rd_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [SIZE_W-1:0]     mem_size_o,
  output logic [31:0]           alu_result_o,
  output logic [31:0]           store_data_o,
  output logic                  busy_o
);
  logic                  is_m, stall_m, load;
  logic [31:0]           alu_res, m_res, res;
  logic [REG_ADDR_W-1:0] sel_rd_q, sel_rd_d;
  logic                  mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [SIZE_W-1:0]     mem_size_q, mem_size_d;
  logic [31:0]           alu_result_q, alu_result_d, store_data_q, store_data_d;

  // Ops 16..23 are RV32M; 24..31 fall through to ADD like any other unused code
  assign is_m = valid_i & (alu_op_i[4:3] == 2'b10);

  always_comb begin
    case (alu_op_i)
      5'd1:    alu_res = operand_a_i - operand_b_i;
      5'd2:    alu_res = operand_a_i << operand_b_i[4:0];
      5'd3:    alu_res = {31'd0, $signed(operand_a_i) < $signed(operand_b_i)};
      5'd4:    alu_res = {31'd0, operand_a_i < operand_b_i};
      5'd5:    alu_res = operand_a_i ^ operand_b_i;
      5'd6:    alu_res = operand_a_i >> operand_b_i[4:0];
      5'd7:    alu_res = $signed(operand_a_i) >>> operand_b_i[4:0];
      5'd8:    alu_res = operand_a_i | operand_b_i;
      5'd9:    alu_res = operand_a_i & operand_b_i;
      default: alu_res = operand_a_i + operand_b_i;
    endcase
  end

`ifdef RV32M_EN
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, prod;
  logic [31:0] den_q, den_d, ma, mb, spec_val, quo, rem;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d, rneg_q, rneg_d, spec_q, spec_d;
  logic        sgn_div, a_neg, b_neg, special;
  logic [32:0] mul_sum, div_sh, div_diff;

  // The datapath works on magnitudes; acc holds {hi, lo} for the product or {remainder, quotient} for divide
  always_comb begin
    sgn_div  = (alu_op_i[2:0] == 3'd4) | (alu_op_i[2:0] == 3'd6);
    a_neg    = operand_a_i[31] & (sgn_div | alu_op_i[2:0] == 3'd1 | alu_op_i[2:0] == 3'd2);
    b_neg    = operand_b_i[31] & (sgn_div | alu_op_i[2:0] == 3'd1);
    ma       = a_neg ? -operand_a_i : operand_a_i;
    mb       = b_neg ? -operand_b_i : operand_b_i;
    special  = alu_op_i[2] & ((operand_b_i == '0) | (sgn_div & operand_a_i == 32'h8000_0000 & operand_b_i == '1));
    spec_val = (operand_b_i == '0) ? (alu_op_i[1] ? operand_a_i : '1) : (alu_op_i[1] ? '0 : 32'h8000_0000);
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, den_q} : 33'd0);
    div_sh   = {acc_q[63:32], acc_q[31]};
    div_diff = div_sh - {1'b0, den_q};
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    den_d    = den_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    spec_d   = spec_q;
    if (flush_i) state_d = IDLE;
    else if (state_q == IDLE && is_m) begin
      state_d = special ? DONE : CALC;
      cnt_d   = 5'd31;
      acc_d   = {32'd0, special ? spec_val : ma};
      den_d   = mb;
      op_d    = alu_op_i[2:0];
      neg_d   = a_neg ^ b_neg;
      rneg_d  = a_neg;
      spec_d  = special;
    end else if (state_q == CALC) begin
      acc_d   = op_q[2] ? (div_diff[32] ? {div_sh[31:0], acc_q[30:0], 1'b0} : {div_diff[31:0], acc_q[30:0], 1'b1})
                        : {mul_sum, acc_q[31:1]};
      cnt_d   = cnt_q - 5'd1;
      state_d = (cnt_q == 5'd0) ? DONE : CALC;
    end else if (state_q == DONE && !stall_i) state_d = IDLE;
    prod  = neg_q ? -acc_q : acc_q;
    quo   = neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem   = rneg_q ? -acc_q[63:32] : acc_q[63:32];
    m_res = spec_q ? acc_q[31:0] : op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'd0) ? prod[31:0] : prod[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      den_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      den_q   <= den_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      spec_q  <= spec_d;
    end
  end

  // The M op is released only in the DONE cycle where the result can actually be captured
  assign stall_m = is_m & ~(state_q == DONE & ~stall_i);
  assign busy_o  = state_q != IDLE;
`else
  assign m_res   = '0;
  assign stall_m = 1'b0;
  assign busy_o  = 1'b0;
`endif

  assign stall_o = stall_m | stall_i;
  assign load    = valid_i & ~flush_i & ~stall_m;
  assign res     = is_m ? m_res : alu_res;

  always_comb begin
    sel_rd_d     = stall_i ? sel_rd_q : load ? sel_rd_i : '0;
    mem_re_d     = stall_i ? mem_re_q : load & mem_re_i;
    mem_we_d     = stall_i ? mem_we_q : load & mem_we_i;
    mem_size_d   = stall_i ? mem_size_q : load ? mem_size_i : '0;
    alu_result_d = stall_i ? alu_result_q : load ? res : '0;
    store_data_d = stall_i ? store_data_q : load ? store_data_i : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_rd_q     <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_size_q   <= '0;
      alu_result_q <= '0;
      store_data_q <= '0;
    end else begin
      sel_rd_q     <= sel_rd_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_size_q   <= mem_size_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
    end
  end

  assign sel_rd_o     = sel_rd_q;
  assign mem_re_o     = mem_re_q;
  assign mem_we_o     = mem_we_q;
  assign mem_size_o   = mem_size_q;
  assign alu_result_o = alu_result_q;
  assign store_data_o = store_data_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized self-checking bench for execute_stage against a reference arithmetic model
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [4:0]  alu_op_i = '0;
  logic [31:0] operand_a_i = '0, operand_b_i = '0, store_data_i = '0;
  logic [4:0]  sel_rd_i = '0;
  logic        mem_re_i = 1'b0, mem_we_i = 1'b0;
  logic [1:0]  mem_size_i = '0;
  logic        stall_i = 1'b0, flush_i = 1'b0;
  logic        stall_o, mem_re_o, mem_we_o, busy_o;
  logic [4:0]  sel_rd_o;
  logic [1:0]  mem_size_o;
  logic [31:0] alu_result_o, store_data_o;
  int          errors = 0, checks = 0;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .alu_op_i(alu_op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .store_data_i(store_data_i),
    .sel_rd_i(sel_rd_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o), .sel_rd_o(sel_rd_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .alu_result_o(alu_result_o), .store_data_o(store_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] up;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    case (op)
      5'd1:  r = a - b;
      5'd2:  r = a << b[4:0];
      5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  r = (a < b) ? 32'd1 : 32'd0;
      5'd5:  r = a ^ b;
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $signed(a) >>> b[4:0];
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd16: r = up[31:0];
      5'd17: begin p = sa * sb; r = p[63:32]; end
      5'd18: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
      5'd19: r = up[63:32];
      5'd20: begin p = (b == 0) ? -64'sd1 : sa / sb; r = p[31:0]; end
      5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: begin p = (b == 0) ? sa : sa % sb; r = p[31:0]; end
      5'd23: r = (b == 0) ? a : a % b;
      default: r = a + b;
    endcase
`ifndef RV32M_EN
    if (op >= 5'd16 && op <= 5'd23) r = 32'd0;
`endif
    return r;
  endfunction

  // Number of sampled cycles for which decode is held before the op is released
  function automatic int stalls(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef RV32M_EN
    if (op < 5'd16 || op > 5'd23) return 0;
    if (op >= 5'd20 && (b == 0 || ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
`else
    return 0;
`endif
  endfunction

  task automatic idle_in();
    valid_i = 1'b0; alu_op_i = '0; operand_a_i = '0; operand_b_i = '0; store_data_i = '0;
    sel_rd_i = '0; mem_re_i = 1'b0; mem_we_i = 1'b0; mem_size_i = '0; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  // Called just after a clock edge; returns just after the edge that captured the instruction
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                        input logic [4:0] rd, input logic re, input logic we, input logic [1:0] sz);
    int n;
    valid_i = 1'b1; alu_op_i = op; operand_a_i = a; operand_b_i = b; store_data_i = sd;
    sel_rd_i = rd; mem_re_i = re; mem_we_i = we; mem_size_i = sz; stall_i = 1'b0; flush_i = 1'b0;
    n = 0;
    #1;
    while (stall_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("stall_cycles op%0d", op), 64'(n), 64'(stalls(op, a, b)));
    @(posedge clk); #1;
    chk($sformatf("result op%0d a=%h b=%h", op, a, b), 64'(alu_result_o), 64'(model(op, a, b)));
    chk("sel_rd", 64'(sel_rd_o), 64'(rd));
    chk("ctl", 64'({mem_re_o, mem_we_o, mem_size_o}), 64'({re, we, sz}));
    chk("store_data", 64'(store_data_o), 64'(sd));
    chk("busy_after", 64'(busy_o), 64'd0);
    idle_in();
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v [4];
    v[0] = 32'd0; v[1] = 32'hFFFF_FFFF; v[2] = 32'h8000_0000; v[3] = 32'd1;
    return ($urandom_range(0, 3) == 0) ? v[$urandom_range(0, 3)] : $urandom;
  endfunction

  initial begin
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 64'(alu_result_o), 64'd0);
    chk("rst_bubble", 64'({sel_rd_o, mem_re_o, mem_we_o, mem_size_o, store_data_o}), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(5'd0, 32'd5, 32'd7, 32'd0, 5'd3, 1'b0, 1'b0, 2'd0);
    run_op(5'd0, 32'h100, 32'h8, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 2'd2);
    run_op(5'd16, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd4, 1'b0, 1'b0, 2'd0);
    run_op(5'd19, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd5, 1'b0, 1'b0, 2'd0);
    run_op(5'd20, -32'sd7, 32'd2, 32'd0, 5'd6, 1'b0, 1'b0, 2'd0);
    run_op(5'd22, -32'sd7, 32'd2, 32'd0, 5'd7, 1'b0, 1'b0, 2'd0);
    run_op(5'd21, 32'd5, 32'd0, 32'd0, 5'd8, 1'b0, 1'b0, 2'd0);
    run_op(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd9, 1'b0, 1'b0, 2'd0);
    run_op(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd10, 1'b0, 1'b0, 2'd0);
    run_op(5'd17, 32'h8000_0000, 32'h8000_0000, 32'd0, 5'd11, 1'b0, 1'b0, 2'd0);
    run_op(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd12, 1'b0, 1'b0, 2'd0);

    // Downstream stall holds an ALU result, then the held instruction completes
    run_op(5'd0, 32'd10, 32'd20, 32'd0, 5'd13, 1'b0, 1'b0, 2'd0);
    valid_i = 1'b1; alu_op_i = 5'd1; operand_a_i = 32'd50; operand_b_i = 32'd8; sel_rd_i = 5'd14; stall_i = 1'b1;
    #1 chk("stall_i_to_stall_o", 64'(stall_o), 64'd1);
    @(posedge clk); #1;
    chk("stall_hold_result", 64'(alu_result_o), 64'd30);
    chk("stall_hold_rd", 64'(sel_rd_o), 64'd13);
    stall_i = 1'b0;
    @(posedge clk); #1;
    chk("after_stall_result", 64'(alu_result_o), 64'd42);

    // Flush of an ALU instruction and an invalid input both load a bubble
    valid_i = 1'b1; alu_op_i = 5'd0; operand_a_i = 32'd1; operand_b_i = 32'd2; sel_rd_i = 5'd1; flush_i = 1'b1;
    @(posedge clk); #1;
    chk("flush_alu_bubble", 64'({sel_rd_o, alu_result_o}), 64'd0);
    idle_in();
    run_op(5'd8, 32'hF0, 32'h0F, 32'h55, 5'd2, 1'b1, 1'b0, 2'd1);
    @(posedge clk); #1;
    chk("invalid_bubble", 64'({sel_rd_o, mem_re_o, mem_size_o, alu_result_o, store_data_o}), 64'd0);

`ifdef RV32M_EN
    // Flush part way through a divide
    valid_i = 1'b1; alu_op_i = 5'd21; operand_a_i = 32'd100; operand_b_i = 32'd3; sel_rd_i = 5'd9;
    repeat (11) @(posedge clk);
    #1 chk("calc_busy", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    chk("flush_m_bubble", 64'({sel_rd_o, alu_result_o}), 64'd0);
    chk("flush_m_busy", 64'(busy_o), 64'd0);
    idle_in();
    #1 chk("flush_m_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;

    // Downstream stall while the M unit sits in DONE
    valid_i = 1'b1; alu_op_i = 5'd16; operand_a_i = 32'd6; operand_b_i = 32'd7; sel_rd_i = 5'd15;
    repeat (33) @(posedge clk);
    #1 stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("done_stall_o", 64'(stall_o), 64'd1);
      chk("done_hold_result", 64'(alu_result_o), 64'd0);
      chk("done_busy", 64'(busy_o), 64'd1);
    end
    stall_i = 1'b0;
    #1 chk("done_release", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    chk("done_result", 64'(alu_result_o), 64'd42);
    chk("done_rd", 64'(sel_rd_o), 64'd15);
    chk("done_idle", 64'(busy_o), 64'd0);
    idle_in();

    // Asynchronous reset in the middle of a multiply
    valid_i = 1'b1; alu_op_i = 5'd17; operand_a_i = 32'd3; operand_b_i = 32'd5;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    idle_in();
    #1 chk("async_rst_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    // Asynchronous reset clears a loaded result without a clock edge
    run_op(5'd5, 32'h1234_5678, 32'hFFFF_0000, 32'hABCD, 5'd31, 1'b1, 1'b0, 2'd2);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_out", 64'({sel_rd_o, mem_re_o, mem_size_o, alu_result_o}), 64'd0);
    chk("async_rst_sd", 64'(store_data_o), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++)
      run_op(5'($urandom_range(0, 31)), pick(), pick(), $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
             2'($urandom_range(0, 2)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
